// File: rtl/spi_agc_pkg.sv
// Shared types for the SPI_AGC control path: sequencer states and the latched SPI mode.
package spi_agc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } mode_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period down-counter: reloads with d on every load and ticks for one cycle when it expires.
module spi_half_period_timer
   import spi_agc_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= period - DIV_W'(1);
      end else if (en && cnt != '0) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK and frame sequencer with chip-select setup/hold and launch/sample strobes.
// Define SPI_SCLK_GEN_GAP_EN to add a GAP state (cs_n high, busy held) after HOLD.
module spi_sclk_gen
   import spi_agc_pkg::*;
#(
   parameter int NUM_CS = 2,
   parameter int DIV_W  = 8,
   parameter int CNT_W  = 6,
   localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  div,
   input  logic [CNT_W-1:0]  nbits,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [SEL_W-1:0]  cs_sel,
   output logic              sclk,
   output logic [NUM_CS-1:0] cs_n,
   output logic              launch,
   output logic              sample,
   output logic              busy,
   output logic              done
);

   state_t state, next_state;
   mode_t  mode_q;

   logic [DIV_W-1:0]  d_q, d_in, period;
   logic [CNT_W-1:0]  nbits_q;
   logic [CNT_W:0]    edge_q, edge_d, edge_next;
   logic              start_ok, abort, tick, load, timer_en, last_edge, leading;
   logic              sclk_d, launch_d, sample_d, busy_d, done_d;
   logic [NUM_CS-1:0] cs_n_d;

   assign d_in      = (div == '0) ? DIV_W'(1) : div;
   assign start_ok  = start && !stop && (nbits != '0) && (32'(cs_sel) < NUM_CS);
   assign abort     = stop && (state != IDLE);
   assign timer_en  = (state != IDLE);
   assign load      = (state == IDLE) ? start_ok : tick;
   assign period    = (state == IDLE) ? d_in : d_q;
   assign edge_next = edge_q + (CNT_W+1)'(1);
   assign last_edge = (edge_next == {nbits_q, 1'b0});
   assign leading   = edge_next[0];

   spi_half_period_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (timer_en),
      .load   (load),
      .period (period),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start_ok) next_state = SETUP;
         SETUP: if (tick) next_state = XFER;
         XFER:  if (tick && last_edge) next_state = HOLD;
         HOLD: begin
            if (tick) begin
`ifdef SPI_SCLK_GEN_GAP_EN
               next_state = GAP;
`else
               next_state = IDLE;
`endif
            end
         end
         GAP:   if (tick) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (abort) next_state = IDLE;
   end

   // The end of SETUP is SCLK edge 1; every later tick up to edge 2*nbits happens in XFER.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
      sclk_d   = sclk;
      cs_n_d   = cs_n;
      busy_d   = busy;
      launch_d = 1'b0;
      sample_d = 1'b0;
      done_d   = 1'b0;
      edge_d   = edge_q;
      case (state)
         IDLE: begin
            sclk_d = cpol;
            if (start_ok) begin
               cs_n_d         = '1;
               cs_n_d[cs_sel] = 1'b0;
               busy_d         = 1'b1;
               edge_d         = '0;
               launch_d       = !cpha;
            end
         end
         SETUP, XFER: begin
            if (tick) begin
               sclk_d = ~sclk;
               edge_d = edge_next;
               if (mode_q.cpha) begin
                  launch_d = leading;
                  sample_d = !leading;
               end else begin
                  sample_d = leading;
                  launch_d = !leading && !last_edge;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_n_d = '1;
`ifdef SPI_SCLK_GEN_GAP_EN
               busy_d = 1'b1;
`else
               busy_d = 1'b0;
               done_d = 1'b1;
`endif
            end
         end
         GAP: begin
            if (tick) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (abort) begin
         sclk_d   = mode_q.cpol;
         cs_n_d   = '1;
         busy_d   = 1'b0;
         launch_d = 1'b0;
         sample_d = 1'b0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk    <= 1'b0;
         cs_n    <= '1;
         launch  <= 1'b0;
         sample  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         edge_q  <= '0;
         d_q     <= '0;
         nbits_q <= '0;
         mode_q  <= '0;
      end else begin
         sclk   <= sclk_d;
         cs_n   <= cs_n_d;
         launch <= launch_d;
         sample <= sample_d;
         busy   <= busy_d;
         done   <= done_d;
         edge_q <= edge_d;
         if (state == IDLE && start_ok) begin
            d_q     <= d_in;
            nbits_q <= nbits;
            mode_q  <= '{cpol: cpol, cpha: cpha};
         end
      end
   end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: frame timing in several modes, abort, and ignored starts.
// Expectations follow the SPI_SCLK_GEN_GAP_EN setting of the build.
module tb_spi_sclk_gen;

   localparam int NUM_CS = 3;
   localparam int DIV_W  = 8;
   localparam int CNT_W  = 6;
   localparam int SEL_W  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [DIV_W-1:0]  div = '0;
   logic [CNT_W-1:0]  nbits = '0;
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic [SEL_W-1:0]  cs_sel = '0;
   logic              sclk;
   logic [NUM_CS-1:0] cs_n;
   logic              launch, sample, busy, done;

   int checks = 0;
   int errors = 0;

   spi_sclk_gen #(
      .NUM_CS (NUM_CS),
      .DIV_W  (DIV_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .div    (div),
      .nbits  (nbits),
      .cpol   (cpol),
      .cpha   (cpha),
      .cs_sel (cs_sel),
      .sclk   (sclk),
      .cs_n   (cs_n),
      .launch (launch),
      .sample (sample),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at cycle c of a frame whose start was sampled at cycle 0:
   // edge k visible at 1+k*d, cs_n high and done at 1+(2n+1)*d (plus d with the gap).
   task automatic check_cycle(input int c, input int d, input int n, input logic cp,
                              input logic ch, input int sel);
      int dn, dd, k, e;
      logic [NUM_CS-1:0] ecs;
      logic el, esm;
      dn = 1 + (2*n + 1) * d;
`ifdef SPI_SCLK_GEN_GAP_EN
      dd = dn + d;
`else
      dd = dn;
`endif
      ecs = '1;
      if (c >= 1 && c < dn) ecs[sel] = 1'b0;
      e = (c < 1) ? 0 : (c - 1) / d;
      if (e > 2*n) e = 2*n;
      el  = 1'b0;
      esm = 1'b0;
      if (!ch && c == 1) el = 1'b1;
      if (c >= 1 + d && (c - 1) % d == 0 && (c - 1) / d <= 2*n) begin
         k = (c - 1) / d;
         if (ch) begin
            el  = k[0];
            esm = !k[0];
         end else begin
            esm = k[0];
            el  = !k[0] && (k < 2*n);
         end
      end
      check("sclk",   c, 32'(sclk),   32'(cp ^ e[0]));
      check("cs_n",   c, 32'(cs_n),   32'(ecs));
      check("launch", c, 32'(launch), 32'(el));
      check("sample", c, 32'(sample), 32'(esm));
      check("busy",   c, 32'(busy),   32'(c >= 1 && c < dd));
      check("done",   c, 32'(done),   32'(c == dd));
   endtask

   task automatic check_idle(input string tag, input logic cp);
      check({tag, "_sclk"},   0, 32'(sclk),   32'(cp));
      check({tag, "_cs_n"},   0, 32'(cs_n),   32'(3'b111));
      check({tag, "_busy"},   0, 32'(busy),   32'(1'b0));
      check({tag, "_done"},   0, 32'(done),   32'(1'b0));
      check({tag, "_strobe"}, 0, 32'({launch, sample}), 32'(2'b00));
   endtask

   initial begin
      int last;
`ifdef SPI_SCLK_GEN_GAP_EN
      int gap_extra = 1;
`else
      int gap_extra = 0;
`endif

      // Reset values
      #12;
      check_idle("reset", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      check_idle("post_reset", 1'b0);

      // Scenario A: div=2, nbits=8, mode 0, cs 0; start and config changes mid-frame ignored
      div = 8'd2; nbits = 6'd8; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
      start = 1'b1;
      last = 36 + 2 * gap_extra;
      for (int c = 1; c <= last; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (c == 11) begin
            start = 1'b0; cs_sel = 2'd0; div = 8'd2; nbits = 6'd8; cpha = 1'b0;
         end
         check_cycle(c, 2, 8, 1'b0, 1'b0, 0);
         if (c == 10) begin
            start = 1'b1; cs_sel = 2'd1; div = 8'd5; nbits = 6'd3; cpha = 1'b1;
         end
         if (gap_extra != 0 && c == 36) start = 1'b1;
         if (gap_extra != 0 && c == 37) start = 1'b0;
      end
      step();
      step();
      check_idle("after_a", 1'b0);

      // Scenario B: same frame in mode 3; SCLK idles high first
      cpol = 1'b1; cpha = 1'b1;
      step();
      step();
      check_idle("idle_cpol1", 1'b1);
      start = 1'b1;
      for (int c = 1; c <= 36 + 2 * gap_extra; c++) begin
         step();
         if (c == 1) start = 1'b0;
         check_cycle(c, 2, 8, 1'b1, 1'b1, 0);
      end

      // Scenario C: div=0 treated as 1, single-bit frame on cs 2
      cpol = 1'b0; cpha = 1'b0; div = 8'd0; nbits = 6'd1; cs_sel = 2'd2;
      step();
      step();
      start = 1'b1;
      for (int c = 1; c <= 5 + gap_extra; c++) begin
         step();
         if (c == 1) start = 1'b0;
         check_cycle(c, 1, 1, 1'b0, 1'b0, 2);
      end

      // Scenario D: stop during cycle 10 of scenario A aborts the frame with no done
      div = 8'd2; nbits = 6'd8; cs_sel = 2'd0;
      step();
      start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (c == 11) stop = 1'b0;
         if (c <= 10) begin
            check_cycle(c, 2, 8, 1'b0, 1'b0, 0);
         end else begin
            check_idle("abort", 1'b0);
         end
         if (c == 10) stop = 1'b1;
      end

      // Scenario E: starts that must be rejected in IDLE
      nbits = 6'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_idle("nbits0", 1'b0);
      nbits = 6'd8; cs_sel = 2'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_idle("bad_sel", 1'b0);
      cs_sel = 2'd1;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      step();
      check_idle("stop_start", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
